// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart transmitter among NUM_REQ byte producers. Requesters are
// served round-robin, but a requester that sends a byte without req_last keeps
// ownership (packet lock) so that its packet goes out contiguously. The lock
// is abandoned if the owner stalls in IDLE for LOCK_TIMEOUT cycles.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req_valid[i]   requester i offers the byte req_data[8*i +: 8]
//   req_data       one byte per requester
//   req_last[i]    the offered byte ends requester i's packet
//   req_ready[i]   one-cycle pulse: byte of requester i accepted
//   uart_tx_start  level to the uart, high while a byte is pending
//   uart_tx_data   byte to the uart, stable while uart_tx_start is high
//   uart_tx_clk    uart bit-tick qualifier (qualifies uart_tx_done)
//   uart_tx_done   uart frame complete
//   uart_tx_busy   uart is transmitting
//   owner_id       current / last granted requester
//   owner_lock     packet lock held by owner_id
//   lock_dropped   one-cycle pulse: lock released by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       uart_tx_start,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_tx_clk,
    input  logic                       uart_tx_done,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       owner_lock,
    output logic                       lock_dropped
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = IDW + 1;
    localparam int CW  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [SW-1:0] NREQ_W    = SW'(NUM_REQ);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SEND,
        ST_DRAIN
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   req_ready_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;
    logic [IDW-1:0]       owner_id_q;
    logic                 owner_lock_q;
    logic                 lock_dropped_q;
    logic [CW-1:0]        counter_q;
    logic [CW-1:0]        counter_d;

    logic [7:0]           req_byte     [NUM_REQ];
    logic [IDW-1:0]       cand_idx     [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic                 rr_hit;
    logic [IDW-1:0]       rr_idx;

    // Per-requester views: the byte lane, the one-hot ready pattern, and the
    // round-robin candidate list. Candidate gi is the requester gi+1 places
    // after the current owner (mod NUM_REQ), so the owner itself comes last.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [SW-1:0] sum_w;

        assign req_byte[gi]     = req_data[8*gi +: 8];
        assign owner_onehot[gi] = (owner_id_q == IDW'(gi));
        assign sum_w            = {1'b0, owner_id_q} + SW'(gi + 1);
        assign cand_idx[gi]     = (sum_w >= NREQ_W) ? IDW'(sum_w - NREQ_W)
                                                    : sum_w[IDW-1:0];
        assign cand_hit[gi]     = req_valid[cand_idx[gi]];
    end

    // Priority pick over the rotated candidate list: lowest offset wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = owner_id_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                rr_hit = 1'b1;
                rr_idx = cand_idx[k];
            end
        end
    end

    // Stall counter increments but never wraps past LOCK_TIMEOUT.
    always_comb begin
        counter_d = counter_q;
        if (counter_q != TIMEOUT_C) begin
            counter_d = counter_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            owner_id_q     <= IDW'(NUM_REQ - 1);
            owner_lock_q   <= 1'b0;
            lock_dropped_q <= 1'b0;
            counter_q      <= '0;
        end else begin
            req_ready_q    <= '0;
            lock_dropped_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Nothing is started while the uart still reports busy,
                    // including right after a reset that hit mid-frame.
                    if (!uart_tx_busy) begin
                        if (!owner_lock_q) begin
                            counter_q <= '0;
                            if (rr_hit) begin
                                owner_id_q <= rr_idx;
                                state_q    <= ST_ACCEPT;
                            end
                        end else if (req_valid[owner_id_q]) begin
                            // Owner wins even on the cycle the timeout
                            // would have expired.
                            counter_q <= '0;
                            state_q   <= ST_ACCEPT;
                        end else if (counter_d == TIMEOUT_C) begin
                            // LOCK_TIMEOUT-th consecutive stalled idle cycle:
                            // release; arbitration resumes next cycle.
                            owner_lock_q   <= 1'b0;
                            lock_dropped_q <= 1'b1;
                            counter_q      <= '0;
                        end else begin
                            counter_q <= counter_d;
                        end
                    end
                end

                ST_ACCEPT: begin
                    // A requester that withdrew its byte between grant and
                    // accept loses it; go back and arbitrate again.
                    if (req_valid[owner_id_q]) begin
                        req_ready_q  <= owner_onehot;
                        tx_data_q    <= req_byte[owner_id_q];
                        tx_start_q   <= 1'b1;
                        owner_lock_q <= ~req_last[owner_id_q];
                        counter_q    <= '0;
                        state_q      <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    // uart_tx_done is only meaningful on a bit tick.
                    if (uart_tx_clk && uart_tx_done) begin
                        tx_start_q <= 1'b0;
                        state_q    <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    // Wait out the stop bit so starts are never back-to-back.
                    if (!uart_tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign uart_tx_start = tx_start_q;
    assign uart_tx_data  = tx_data_q;
    assign owner_id      = owner_id_q;
    assign owner_lock    = owner_lock_q;
    assign lock_dropped  = lock_dropped_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, LOCK_TIMEOUT=16). A small
// uart model either answers automatically (busy on start, done on a bit tick
// three cycles later, busy clear two cycles after that) or is driven by hand.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_clk = 1'b0;
    logic        uart_tx_done = 1'b0;
    logic        uart_tx_busy = 1'b0;
    logic [1:0]  owner_id;
    logic        owner_lock;
    logic        lock_dropped;

    int errors = 0;
    int checks = 0;

    logic auto_uart = 1'b1;
    logic m_busy = 1'b0;
    logic m_clk = 1'b0;
    logic m_done = 1'b0;
    int   ucnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_clk   (uart_tx_clk),
        .uart_tx_done  (uart_tx_done),
        .uart_tx_busy  (uart_tx_busy),
        .owner_id      (owner_id),
        .owner_lock    (owner_lock),
        .lock_dropped  (lock_dropped)
    );

    always #5 clk = ~clk;

    // uart model, updated on the falling edge
    always @(negedge clk) begin
        if (auto_uart) begin
            uart_tx_clk  = 1'b0;
            uart_tx_done = 1'b0;
            if (!rst_n) begin
                uart_tx_busy = 1'b0;
                ucnt = 0;
            end else if (uart_tx_busy) begin
                ucnt = ucnt + 1;
                if (ucnt == 3) begin
                    uart_tx_clk  = 1'b1;
                    uart_tx_done = 1'b1;
                end
                if (ucnt == 5) uart_tx_busy = 1'b0;
            end else if (uart_tx_start) begin
                uart_tx_busy = 1'b1;
                ucnt = 0;
            end
        end else begin
            uart_tx_busy = m_busy;
            uart_tx_clk  = m_clk;
            uart_tx_done = m_done;
        end
    end

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        int          id;
        logic [7:0]  bdat;
        logic        lock;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for a ready pulse and check who was granted and what went to the uart.
    task automatic expect_grant(input string name, input int id, input logic [7:0] bd,
                                input logic lk);
        bit         ok;
        logic [3:0] exp_r;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (req_ready != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout_fail({name, "_ready"});
        end else begin
            exp_r = 4'b0001 << id;
            chk({name, "_ready"}, 32'(req_ready), 32'(exp_r));
            chk({name, "_data"},  32'(uart_tx_data), 32'(bd));
            chk({name, "_owner"}, 32'(owner_id), 32'(id));
            chk({name, "_lock"},  32'(owner_lock), 32'(lk));
            chk({name, "_start"}, 32'(uart_tx_start), 32'd1);
            $display("grant %s: ready=%b data=%02h owner=%0d lock=%0d", name, req_ready,
                     uart_tx_data, owner_id, owner_lock);
        end
    endtask

    task automatic wait_busy(input string name, input logic level);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (uart_tx_busy == level) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;

        //             rst  valid    data           last     id bdat   lock
        tbl[0] = '{1'b1, 4'b0001, 32'h0000_0041, 4'b0001, 0, 8'h41, 1'b0};
        tbl[1] = '{1'b1, 4'b1111, 32'hA3A2_A1A0, 4'b1111, 0, 8'hA0, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 32'hA3A2_A1B0, 4'b1111, 1, 8'hA1, 1'b0};
        tbl[3] = '{1'b0, 4'b1111, 32'hA3A2_B1B0, 4'b1111, 2, 8'hA2, 1'b0};
        tbl[4] = '{1'b0, 4'b1111, 32'hA3B2_B1B0, 4'b1111, 3, 8'hA3, 1'b0};
        tbl[5] = '{1'b0, 4'b1111, 32'hB3B2_B1B0, 4'b1111, 0, 8'hB0, 1'b0};
        tbl[6] = '{1'b0, 4'b1111, 32'hB3B2_B1C0, 4'b1101, 1, 8'hB1, 1'b1};
        tbl[7] = '{1'b0, 4'b1111, 32'hB3B2_D1C0, 4'b1111, 1, 8'hD1, 1'b0};
        tbl[8] = '{1'b0, 4'b1111, 32'hB3B2_E1C0, 4'b1111, 2, 8'hB2, 1'b0};

        // Reset state
        do_reset();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(uart_tx_start), 32'd0);
        chk("rst_data",  32'(uart_tx_data), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd3);
        chk("rst_lock",  32'(owner_lock), 32'd0);
        chk("rst_drop",  32'(lock_dropped), 32'd0);
        $display("reset: ready=%b start=%0d owner=%0d", req_ready, uart_tx_start, owner_id);

        // Table: single requester, full round-robin rotation, short locked packet
        for (int r = 0; r < 9; r++) begin
            if (tbl[r].rst) do_reset();
            req_valid = tbl[r].valid;
            req_data  = tbl[r].data;
            req_last  = tbl[r].last;
            expect_grant($sformatf("vec%0d", r), tbl[r].id, tbl[r].bdat, tbl[r].lock);
            tick();
            chk($sformatf("vec%0d_pulse", r), 32'(req_ready), 32'd0);
        end

        // Packet from req1 stays contiguous, then req2 before req0
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_1000;
        req_last  = 4'b0000;
        expect_grant("t3_b0", 1, 8'h10, 1'b1);
        req_valid = 4'b0111;
        req_data  = 32'h0030_1120;
        req_last  = 4'b0101;
        expect_grant("t3_b1", 1, 8'h11, 1'b1);
        req_data  = 32'h0030_1220;
        req_last  = 4'b0111;
        expect_grant("t3_b2", 1, 8'h12, 1'b0);
        req_valid = 4'b0101;
        expect_grant("t3_req2", 2, 8'h30, 1'b0);
        req_valid = 4'b0001;
        expect_grant("t3_req0", 0, 8'h20, 1'b0);

        // Lock timeout: req3 stalls mid-packet while req0 waits
        do_reset();
        req_valid = 4'b1000;
        req_data  = 32'h5500_0000;
        req_last  = 4'b0000;
        expect_grant("t4_first", 3, 8'h55, 1'b1);
        req_valid = 4'b0001;
        req_data  = 32'h0000_0066;
        req_last  = 4'b0001;
        wait_busy("t4_busy_rise", 1'b1);
        wait_busy("t4_busy_fall", 1'b0);
        // The arbiter left DRAIN on the edge just before this sample.
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            k++;
            if (lock_dropped) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            timeout_fail("t4_drop");
        end else begin
            chk("t4_drop_delay", 32'(k), 32'd16);
            chk("t4_lock_clear", 32'(owner_lock), 32'd0);
            chk("t4_owner_held", 32'(owner_id), 32'd3);
            $display("lock drop: after %0d cycles", k);
            tick();
            chk("t4_regrant", 32'(owner_id), 32'd0);
            chk("t4_drop_pulse", 32'(lock_dropped), 32'd0);
            expect_grant("t4_second", 0, 8'h66, 1'b0);
        end

        // uart_tx_done without a bit tick is ignored; no start while busy
        auto_uart = 1'b0;
        m_busy = 1'b0;
        m_clk  = 1'b0;
        m_done = 1'b0;
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        req_last  = 4'b0100;
        expect_grant("t5_first", 2, 8'h5A, 1'b0);
        m_busy   = 1'b1;
        req_data = 32'h005B_0000;
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        chk("t5_done_no_clk", 32'(uart_tx_start), 32'd1);
        m_clk = 1'b1;
        tick();
        m_clk = 1'b0;
        tick();
        chk("t5_clk_no_done", 32'(uart_tx_start), 32'd1);
        chk("t5_data_hold", 32'(uart_tx_data), 32'h5A);
        m_clk  = 1'b1;
        m_done = 1'b1;
        tick();
        m_clk  = 1'b0;
        m_done = 1'b0;
        chk("t5_start_fell", 32'(uart_tx_start), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t5_busy_ready%0d", c), 32'(req_ready), 32'd0);
            chk($sformatf("t5_busy_start%0d", c), 32'(uart_tx_start), 32'd0);
        end
        m_busy = 1'b0;
        expect_grant("t5_second", 2, 8'h5B, 1'b0);

        // Reset during SEND with the uart still busy afterwards
        m_busy = 1'b0;
        do_reset();
        req_valid = 4'b0010;
        req_data  = 32'h0000_7700;
        req_last  = 4'b0010;
        expect_grant("t6_first", 1, 8'h77, 1'b0);
        m_busy = 1'b1;
        tick();
        tick();
        chk("t6_in_send", 32'(uart_tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_start_async", 32'(uart_tx_start), 32'd0);
        chk("t6_owner_rst", 32'(owner_id), 32'd3);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t6_busy_ready%0d", c), 32'(req_ready), 32'd0);
        end
        m_busy = 1'b0;
        expect_grant("t6_after", 1, 8'h77, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
